// File: rtl/fpga_cfg_loader_pkg.sv
// Shared constants and types for the configuration loader.
package fpga_cfg_pkg;

  localparam logic [7:0]  CMD_LOAD_CLB  = 8'hA5;
  localparam logic [7:0]  CMD_LOAD_CONN = 8'h5A;
  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CRC_HI,
    CRC_LO,
    FIN
  } cfg_state_e;

  typedef enum logic {
    CHAIN_CLB,
    CHAIN_CONN
  } cfg_chain_e;

  // Bits taken from the final payload byte of a chain of length len.
  function automatic logic [3:0] last_bits(input int unsigned len);
    return (len % 8 == 0) ? 4'd8 : 4'(len % 8);
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte-wide valid/ready bitstream channel into the loader.
interface fpga_cfg_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fpga_cfg_loader_crc16.sv
// Bit-serial CRC-16-CCITT, one message bit per enabled cycle.
module cfg_crc16_serial
  import fpga_cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[15] ^ bit_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream front-end: decodes a command byte, serialises the payload into
// the CLB or connection scan chain, checks the CRC trailer, gates core reset.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned CLB_CHAIN_LEN  = 1024,
  parameter int unsigned CONN_CHAIN_LEN = 4096,
  parameter bit          CRC_EN         = 1'b1
) (
  input  logic             scan_clk,
  input  logic             reset,
  fpga_cfg_loader_if.slave cfg,
  output logic             clb_scan_in,
  output logic             clb_scan_en,
  output logic             conn_scan_in,
  output logic             conn_scan_en,
  output logic             core_reset,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int unsigned MAX_LEN   = (CLB_CHAIN_LEN > CONN_CHAIN_LEN) ? CLB_CHAIN_LEN
                                                                       : CONN_CHAIN_LEN;
  localparam int unsigned CW        = $clog2(MAX_LEN) + 1;
  localparam int unsigned MAX_BYTES = (MAX_LEN + 7) / 8;
  localparam int unsigned BW        = $clog2(MAX_BYTES) + 1;

  localparam logic [CW-1:0] CLB_LEN_C    = CW'(CLB_CHAIN_LEN);
  localparam logic [CW-1:0] CONN_LEN_C   = CW'(CONN_CHAIN_LEN);
  localparam logic [BW-1:0] CLB_BYTES_C  = BW'((CLB_CHAIN_LEN + 7) / 8);
  localparam logic [BW-1:0] CONN_BYTES_C = BW'((CONN_CHAIN_LEN + 7) / 8);
  localparam logic [3:0]    CLB_LAST_C   = last_bits(CLB_CHAIN_LEN);
  localparam logic [3:0]    CONN_LAST_C  = last_bits(CONN_CHAIN_LEN);

  cfg_state_e    state_q;
  cfg_chain_e    chain_q;
  logic [CW-1:0] len_q, bits_q;
  logic [BW-1:0] bytes_q;
  logic [3:0]    last_q, rem_q;
  logic [7:0]    shreg_q, crc_hi_q;
  logic          clb_in_q, clb_en_q, conn_in_q, conn_en_q;
  logic          core_rst_q, busy_q, done_q, err_q;

  logic          ready_c, xfer;
  logic          shift_v, shift_b;
  logic [3:0]    nb;
  logic [15:0]   crc_val;

  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      IDLE:           ready_c = 1'b1;
      SHIFT:          ready_c = (rem_q <= 4'd1) && (bytes_q != '0);
      CRC_HI, CRC_LO: ready_c = 1'b1;
      default:        ready_c = 1'b0;
    endcase
  end

  assign cfg.cfg_ready = ready_c;
  assign xfer          = cfg.cfg_valid && ready_c;

  // A byte accepted with rem=0 contributes its MSB in the same cycle, so a
  // resumed stream costs no extra bubble after a stall.
  always_comb begin
    nb      = (bytes_q == BW'(1)) ? last_q : 4'd8;
    shift_v = 1'b0;
    shift_b = 1'b0;
    if (state_q == SHIFT) begin
      if (rem_q != '0) begin
        shift_v = 1'b1;
        shift_b = shreg_q[7];
      end else if (xfer) begin
        shift_v = 1'b1;
        shift_b = cfg.cfg_data[7];
      end
    end
  end

  cfg_crc16_serial u_crc (
    .clk_i (scan_clk),
    .rst_i (reset),
    .clr_i (state_q == IDLE),
    .en_i  (shift_v),
    .bit_i (shift_b),
    .crc_o (crc_val)
  );

  always_ff @(posedge scan_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chain_q    <= CHAIN_CLB;
      len_q      <= '0;
      bits_q     <= '0;
      bytes_q    <= '0;
      last_q     <= '0;
      rem_q      <= '0;
      shreg_q    <= '0;
      crc_hi_q   <= '0;
      clb_in_q   <= 1'b0;
      clb_en_q   <= 1'b0;
      conn_in_q  <= 1'b0;
      conn_en_q  <= 1'b0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clb_en_q  <= 1'b0;
      conn_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (cfg.cfg_data == CMD_LOAD_CLB || cfg.cfg_data == CMD_LOAD_CONN) begin
              if (cfg.cfg_data == CMD_LOAD_CLB) begin
                chain_q <= CHAIN_CLB;
                len_q   <= CLB_LEN_C;
                bytes_q <= CLB_BYTES_C;
                last_q  <= CLB_LAST_C;
              end else begin
                chain_q <= CHAIN_CONN;
                len_q   <= CONN_LEN_C;
                bytes_q <= CONN_BYTES_C;
                last_q  <= CONN_LAST_C;
              end
              bits_q     <= '0;
              rem_q      <= '0;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              core_rst_q <= 1'b1;
              state_q    <= SHIFT;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (shift_v) begin
            if (chain_q == CHAIN_CLB) begin
              clb_en_q <= 1'b1;
              clb_in_q <= shift_b;
            end else begin
              conn_en_q <= 1'b1;
              conn_in_q <= shift_b;
            end
            bits_q <= bits_q + CW'(1);
            if (bits_q + CW'(1) == len_q) begin
              state_q <= CRC_EN ? CRC_HI : FIN;
              done_q  <= !CRC_EN;
            end
          end
          if (xfer) begin
            bytes_q <= bytes_q - BW'(1);
            if (rem_q == '0) begin
              shreg_q <= {cfg.cfg_data[6:0], 1'b0};
              rem_q   <= nb - 4'd1;
            end else begin
              shreg_q <= cfg.cfg_data;
              rem_q   <= nb;
            end
          end else if (rem_q != '0) begin
            shreg_q <= shreg_q << 1;
            rem_q   <= rem_q - 4'd1;
          end
        end
        CRC_HI: begin
          if (xfer) begin
            crc_hi_q <= cfg.cfg_data;
            state_q  <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (xfer) begin
            if ({crc_hi_q, cfg.cfg_data} != crc_val) err_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          busy_q     <= 1'b0;
          core_rst_q <= err_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clb_scan_in  = clb_in_q;
  assign clb_scan_en  = clb_en_q;
  assign conn_scan_in = conn_in_q;
  assign conn_scan_en = conn_en_q;
  assign core_reset   = core_rst_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: two instances (CRC off / CRC on) with short chains.
module tb_fpga_cfg_loader;
  import fpga_cfg_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpga_cfg_loader_if if0 ();
  fpga_cfg_loader_if if1 ();

  logic [1:0] valid = '0;
  logic [7:0] din [2];
  wire  [1:0] rdy, clb_in, clb_en, conn_in, conn_en, core_rst, busy, done, err;

  assign if0.cfg_valid = valid[0];
  assign if1.cfg_valid = valid[1];
  assign if0.cfg_data  = din[0];
  assign if1.cfg_data  = din[1];
  assign rdy[0]        = if0.cfg_ready;
  assign rdy[1]        = if1.cfg_ready;

  fpga_cfg_loader #(.CLB_CHAIN_LEN(12), .CONN_CHAIN_LEN(20), .CRC_EN(1'b0)) dut0 (
    .scan_clk(clk), .reset(rst), .cfg(if0),
    .clb_scan_in(clb_in[0]), .clb_scan_en(clb_en[0]),
    .conn_scan_in(conn_in[0]), .conn_scan_en(conn_en[0]),
    .core_reset(core_rst[0]), .cfg_busy(busy[0]), .cfg_done(done[0]), .cfg_err(err[0])
  );

  fpga_cfg_loader #(.CLB_CHAIN_LEN(12), .CONN_CHAIN_LEN(20), .CRC_EN(1'b1)) dut1 (
    .scan_clk(clk), .reset(rst), .cfg(if1),
    .clb_scan_in(clb_in[1]), .clb_scan_en(clb_en[1]),
    .conn_scan_in(conn_in[1]), .conn_scan_en(conn_en[1]),
    .core_reset(core_rst[1]), .cfg_busy(busy[1]), .cfg_done(done[1]), .cfg_err(err[1])
  );

  int checks = 0;
  int errors = 0;

  // Monitor: samples just after each rising edge, watching the active DUT.
  int    act = 0, mon_ch = 0, cyc = 0;
  bitq_t mon_bits;
  int    mon_first = -1, mon_last = -1, mon_wrong = 0, mon_done = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if ((mon_ch == 0) ? clb_en[act] : conn_en[act]) begin
      mon_bits.push_back((mon_ch == 0) ? clb_in[act] : conn_in[act]);
      if (mon_first < 0) mon_first = cyc;
      mon_last = cyc;
    end
    if (((mon_ch == 0) ? conn_en[act] : clb_en[act]) || clb_en[1-act] || conn_en[1-act])
      mon_wrong++;
    if (done[act]) mon_done++;
  end

  task automatic mon_clear(input int d, input int ch);
    act = d;
    mon_ch = ch;
    mon_bits.delete();
    mon_first = -1;
    mon_last = -1;
    mon_wrong = 0;
    mon_done = 0;
  endtask

  function automatic logic [15:0] crc16(input bitq_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      if (c[15] ^ q[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send(input int d, input logic [7:0] b);
    int n;
    n = 0;
    din[d] = b;
    valid[d] = 1'b1;
    while (!rdy[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_timeout d%0d byte %02h: ready never seen within %0d cycles", d, b, n);
    end
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  task automatic do_load(input int d, input int ch, input bq_t pay,
                         input int stall_idx, input int stall_len, input bit corrupt);
    int          len, gap_exp, gap, n;
    bit          crc_on, exp_err;
    bitq_t       exp_bits;
    logic [15:0] crc;
    logic [31:0] got_v, exp_v;
    logic [7:0]  b;
    len = (ch == 0) ? 12 : 20;
    crc_on = (d == 1);
    for (int i = 0; i < len; i++) begin
      b = pay[i/8];
      exp_bits.push_back(b[7 - (i % 8)]);
    end
    crc = crc16(exp_bits);
    gap_exp = (stall_idx >= 1 && stall_len >= 1) ? stall_len - 1 : 0;
    exp_err = crc_on && corrupt;

    mon_clear(d, ch);
    send(d, (ch == 0) ? CMD_LOAD_CLB : CMD_LOAD_CONN);
    checks++;
    if (busy[d] !== 1'b1 || err[d] !== 1'b0 || core_rst[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_state d%0d: busy/err/core_reset=%b%b%b required 101",
               d, busy[d], err[d], core_rst[d]);
    end
    for (int k = 0; k < pay.size(); k++) begin
      if (k == stall_idx && stall_len > 0) begin
        n = 0;
        while (!rdy[d] && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (stall_len) @(negedge clk);
      end
      send(d, pay[k]);
    end
    if (crc_on) begin
      send(d, crc[15:8]);
      send(d, crc[7:0] ^ {7'd0, corrupt});
    end
    n = 0;
    while (busy[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL busy_timeout d%0d: busy still %b after %0d cycles", d, busy[d], n);
    end
    repeat (2) @(negedge clk);

    got_v = '0;
    exp_v = '0;
    for (int i = 0; i < mon_bits.size() && i < 32; i++) got_v[i] = mon_bits[i];
    for (int i = 0; i < len; i++) exp_v[i] = exp_bits[i];
    checks++;
    if (mon_bits.size() != len) begin
      errors++;
      $display("FAIL bit_count d%0d ch%0d: got %0d required %0d", d, ch, mon_bits.size(), len);
    end
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL bit_seq d%0d ch%0d: got %h required %h (bit0 first)", d, ch, got_v, exp_v);
    end
    gap = (mon_first < 0) ? -1 : (mon_last - mon_first + 1 - mon_bits.size());
    checks++;
    if (gap != gap_exp) begin
      errors++;
      $display("FAIL enable_gap d%0d ch%0d: got %0d required %0d", d, ch, gap, gap_exp);
    end
    checks++;
    if (mon_wrong != 0) begin
      errors++;
      $display("FAIL other_chain_en d%0d: got %0d cycles required 0", d, mon_wrong);
    end
    checks++;
    if (mon_done != 1) begin
      errors++;
      $display("FAIL done_pulses d%0d: got %0d required 1", d, mon_done);
    end
    checks++;
    if (err[d] !== exp_err) begin
      errors++;
      $display("FAIL cfg_err d%0d: got %b required %b", d, err[d], exp_err);
    end
    checks++;
    if (core_rst[d] !== exp_err) begin
      errors++;
      $display("FAIL core_reset d%0d: got %b required %b", d, core_rst[d], exp_err);
    end
    checks++;
    if (rdy[d] !== 1'b1 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL back_idle d%0d: ready/busy=%b%b required 10", d, rdy[d], busy[d]);
    end
  endtask

  task automatic test_reset;
    valid = '0;
    din[0] = '0;
    din[1] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_clear(0, 0);
    checks++;
    if (core_rst !== 2'b11 || clb_en !== 2'b00 || conn_en !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: core_reset=%b clb_en=%b conn_en=%b required 11 00 00",
               core_rst, clb_en, conn_en);
    end
    checks++;
    if (busy !== 2'b00 || err !== 2'b00 || done !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: busy=%b err=%b done=%b required 00 00 00", busy, err, done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rdy !== 2'b11) begin
      errors++;
      $display("FAIL idle_ready: got %b required 11", rdy);
    end
    checks++;
    if (mon_done != 0 || mon_wrong != 0 || mon_bits.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: done=%0d stray_en=%0d bits=%0d required 0 0 0",
               mon_done, mon_wrong, mon_bits.size());
    end
  endtask

  task automatic test_clb_stream;
    bq_t p;
    p.push_back(8'hB3);
    p.push_back(8'hC0);
    do_load(0, 0, p, -1, 0, 1'b0);
  endtask

  task automatic test_clb_stall;
    bq_t p;
    p.push_back(8'hB3);
    p.push_back(8'hC0);
    do_load(0, 0, p, 1, 5, 1'b0);
  endtask

  task automatic test_conn_crc;
    bq_t p;
    for (int i = 0; i < 3; i++) p.push_back(8'($urandom));
    do_load(1, 1, p, -1, 0, 1'b0);
    do_load(1, 1, p, -1, 0, 1'b1);
  endtask

  task automatic test_bad_cmd;
    bq_t p;
    mon_clear(0, 0);
    send(0, 8'h3C);
    repeat (3) @(negedge clk);
    checks++;
    if (err[0] !== 1'b1) begin
      errors++;
      $display("FAIL bad_cmd_err: got %b required 1", err[0]);
    end
    checks++;
    if (mon_done != 1) begin
      errors++;
      $display("FAIL bad_cmd_done: got %0d pulses required 1", mon_done);
    end
    checks++;
    if (mon_bits.size() != 0 || mon_wrong != 0) begin
      errors++;
      $display("FAIL bad_cmd_scan: bits=%0d stray_en=%0d required 0 0", mon_bits.size(), mon_wrong);
    end
    checks++;
    if (rdy[0] !== 1'b1 || busy[0] !== 1'b0 || core_rst[0] !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd_idle: ready/busy/core_reset=%b%b%b required 100",
               rdy[0], busy[0], core_rst[0]);
    end
    p.push_back(8'h6E);
    p.push_back(8'h90);
    do_load(0, 0, p, -1, 0, 1'b0);
  endtask

  task automatic test_reset_midload;
    bq_t p;
    int  n;
    mon_clear(0, 0);
    send(0, CMD_LOAD_CLB);
    send(0, 8'hB3);
    n = 0;
    while (mon_bits.size() < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL midload_progress: got %0d bits required 5", mon_bits.size());
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (clb_en[0] !== 1'b0 || core_rst[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: clb_en/core_reset/busy=%b%b%b required 010",
               clb_en[0], core_rst[0], busy[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    p.push_back(8'hB3);
    p.push_back(8'hC0);
    do_load(0, 0, p, -1, 0, 1'b0);
  endtask

  task automatic test_random;
    bq_t p;
    int  d, ch, nbytes;
    for (int it = 0; it < 16; it++) begin
      d = $urandom_range(0, 1);
      ch = $urandom_range(0, 1);
      nbytes = (ch == 0) ? 2 : 3;
      p.delete();
      for (int i = 0; i < nbytes; i++) p.push_back(8'($urandom));
      do_load(d, ch, p, $urandom_range(0, nbytes - 1), $urandom_range(0, 6),
              (d == 1) && ($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_clb_stream();
    test_clb_stall();
    test_conn_crc();
    test_bad_cmd();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
